mips_muldiv_unit: RTL and testbench

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

---
 rtl/mips_muldiv_unit.sv | 119 +++++++++++
 tb/tb_mips_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: 32 shift-add / restoring-divide steps,
// then a sign-fix cycle, giving a fixed 33-edge latency from start to HI/LO update.
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clock_enable,
  input  logic        start,
  input  logic [1:0]  op_code,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;            // multiplicand or divisor magnitude
  logic [63:0] acc_q;              // {partial product hi, multiplier} or {remainder, quotient}
  logic        is_div_q, neg_q, rem_neg_q, div_zero_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, shifted, diff;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign sgn   = ~op_code[0];
  assign a_mag = (sgn && op1[31]) ? (~op1 + 32'd1) : op1;
  assign b_mag = (sgn && op2[31]) ? (~op2 + 32'd1) : op2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    shifted = acc_q[63:31];
    diff    = shifted - {1'b0, mcand_q};
    // Remainder stays below the divisor, so bit 32 of diff is a clean borrow flag
    if (is_div_q)
      acc_step = diff[32] ? {shifted[31:0], acc_q[30:0], 1'b0}
                          : {diff[31:0], acc_q[30:0], 1'b1};
    else
      acc_step = {add_sum, acc_q[31:1]};
    prod_fix = neg_q     ? (~acc_q + 64'd1)         : acc_q;
    quo_fix  = neg_q     ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
    rem_fix  = rem_neg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      mcand_q    <= 32'd0;
      acc_q      <= 64'd0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
    end else if (clock_enable) begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q    <= b_mag;
            acc_q      <= {32'd0, a_mag};
            is_div_q   <= op_code[1];
            neg_q      <= sgn & (op1[31] ^ op2[31]);
            rem_neg_q  <= sgn & op1[31];
            div_zero_q <= (op2 == 32'd0);
            cnt_q      <= 5'd0;
          end else begin
            if (wr_hi) hi_q <= wdata;
            if (wr_lo) lo_q <= wdata;
          end
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
        end
        FIX: begin
          // Divide by zero leaves quotient all-ones; remainder path already restores op1
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= div_zero_q ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized + directed bench for mips_muldiv_unit against an operation-level model.
module tb_mips_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b0, clock_enable = 1'b1, start = 1'b0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] op1 = 32'd0, op2 = 32'd0, wdata = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;

  mips_muldiv_unit dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start),
    .op_code(op_code), .op1(op1), .op2(op2), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge done) done_cnt <= done_cnt + 1;

  // Architectural result {hi,lo} from plain integer arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] oc, input logic [31:0] a, b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (oc)
      2'd0: return 64'(sa * sb);
      2'd1: return 64'(ua * ub);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb); r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(ua / ub); r = 32'(ua % ub);
        return {r, q};
      end
    endcase
  endfunction

  // Operation-level model: an accepted op publishes its result 33 enabled edges later
  logic        m_busy, m_done;
  int          m_rem;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      m_hi <= 32'd0; m_lo <= 32'd0; m_res <= 64'd0;
    end else if (clock_enable) begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_rem <= 33; m_res <= model_res(op_code, op1, op2);
        end else begin
          if (wr_hi) m_hi <= wdata;
          if (wr_lo) m_lo <= wdata;
        end
      end else if (m_rem == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_hi <= m_res[63:32]; m_lo <= m_res[31:0];
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_busy", 64'(busy), 64'(m_busy));
    check("cmp_done", 64'(done), 64'(m_done));
    check("cmp_hi", 64'(hi), 64'(m_hi));
    check("cmp_lo", 64'(lo), 64'(m_lo));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [1:0] oc, input logic [31:0] a, input logic [31:0] b,
                        output int t0);
    op_code = oc; op1 = a; op2 = b; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0; op1 = $urandom; op2 = $urandom; op_code = 2'($urandom);
  endtask

  task automatic wait_done(input int t0, output int lat);
    int n;
    n = 0;
    while (!done && n < 300) begin tick(); n++; end
    check("done_seen", 64'(done), 64'd1);
    lat = cyc - t0;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  d_op [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2};
  logic [31:0] d_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9};
  logic [31:0] d_b  [6] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
  logic [31:0] d_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd0, 32'hFFFFFFF9};
  logic [31:0] d_lo [6] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  initial begin
    int t0, lat, dc;
    repeat (2) tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      launch(d_op[i], d_a[i], d_b[i], t0);
      wait_done(t0, lat);
      check("dir_lat", 64'(lat), 64'd34);
      check("dir_hi", 64'(hi), 64'(d_hi[i]));
      check("dir_lo", 64'(lo), 64'(d_lo[i]));
      tick();
    end

    // Start and MTLO while busy are dropped
    launch(2'd1, 32'd6, 32'd7, t0);
    repeat (10) tick();
    op_code = 2'd3; op1 = 32'd1; op2 = 32'd1; start = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
    tick();
    start = 1'b0; wr_lo = 1'b0;
    wait_done(t0, lat);
    check("busy_lat", 64'(lat), 64'd34);
    check("busy_hi", 64'(hi), 64'd0);
    check("busy_lo", 64'(lo), 64'd42);
    tick();

    // Clock-enable stall stretches latency, single done pulse
    dc = done_cnt;
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, t0);
    repeat (10) tick();
    clock_enable = 1'b0;
    repeat (5) tick();
    clock_enable = 1'b1;
    wait_done(t0, lat);
    check("ce_lat", 64'(lat), 64'd39);
    repeat (3) tick();
    check("ce_pulses", 64'(done_cnt - dc), 64'd1);
    check("ce_hi", 64'(hi), 64'hFFFFFFFE);
    check("ce_lo", 64'(lo), 64'h00000001);

    // MTHI, then reset mid-operation
    wr_hi = 1'b1; wdata = 32'hAAAA5555;
    tick();
    wr_hi = 1'b0;
    check("mthi", 64'(hi), 64'hAAAA5555);
    launch(2'd0, $urandom, $urandom, t0);
    repeat (20) tick();
    dc = done_cnt;
    reset = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("arst_no_done", 64'(done_cnt - dc), 64'd0);
    launch(2'd0, 32'hFFFFFFFD, 32'd5, t0);
    wait_done(t0, lat);
    check("post_rst_lat", 64'(lat), 64'd34);
    check("post_rst_lo", 64'(lo), 64'hFFFFFFF1);
    tick();

    for (int c = 0; c < 4000; c++) begin
      clock_enable = ($urandom_range(0, 9) != 0);
      start   = ($urandom_range(0, 5) == 0);
      op_code = 2'($urandom);
      op1 = rnd();
      op2 = rnd();
      wr_hi = ($urandom_range(0, 7) == 0);
      wr_lo = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      reset = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset = 1'b1; clock_enable = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (40) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
